// File: rtl/w_expand_stage.sv
// SHA-2 message-schedule expansion stage: extends a 16-word window by
// WORDS_PER_STAGE words (LANES per clock) and returns the newest 16 words.
module w_expand_stage #(
  parameter int WORD_S          = 32,
  parameter int WORDS_PER_STAGE = 16,
  parameter int LANES           = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORD_S-1:0]  win,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORD_S-1:0]  wout,
  output logic                  busy
);

  generate
    if (!((WORD_S == 32 || WORD_S == 64) &&
          WORDS_PER_STAGE >= 1 && WORDS_PER_STAGE <= 48 &&
          (LANES == 1 || LANES == 2) &&
          (WORDS_PER_STAGE % LANES) == 0)) begin : g_bad_params
      $error("w_expand_stage: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(WORDS_PER_STAGE - LANES);
  localparam logic [5:0] CNT_STEP = 6'(LANES);

  state_t            state_q, state_d;
  logic [5:0]        cnt_q;
  logic [WORD_S-1:0] w_q [16];
  logic [WORD_S-1:0] nw0, nw1;
  logic              accept, step, last;

  function automatic logic [WORD_S-1:0] rotr(input logic [WORD_S-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_S - n));
  endfunction

  function automatic logic [WORD_S-1:0] sig0(input logic [WORD_S-1:0] x);
    if (WORD_S == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_S-1:0] sig1(input logic [WORD_S-1:0] x);
    if (WORD_S == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // w_q is a sliding window: w_q[0] is E[j-16] for the next word E[j].
  // The second lane's word E[j+1] depends only on words already in the window.
  always_comb begin
    nw0 = sig1(w_q[14]) + w_q[9]  + sig0(w_q[1]) + w_q[0];
    nw1 = sig1(w_q[15]) + w_q[10] + sig0(w_q[2]) + w_q[1];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = (cnt_q == CNT_LAST);
    if (!reset) begin
      case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept  = 1'b1;
            state_d = CALC;
          end
        end
        CALC: begin
          busy = 1'b1;
          step = 1'b1;
          if (last) state_d = HOLD;
        end
        HOLD: begin
          busy      = 1'b1;
          out_valid = 1'b1;
          in_ready  = out_ready;
          if (out_ready) begin
            if (in_valid) begin
              accept  = 1'b1;
              state_d = CALC;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)            cnt_q <= '0;
      else if (step && !last) cnt_q <= cnt_q + CNT_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= win[i*WORD_S +: WORD_S];
    end else if (step) begin
      if (LANES == 1) begin
        for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= nw0;
      end else begin
        for (int unsigned i = 0; i < 14; i++) w_q[i] <= w_q[i+2];
        w_q[14] <= nw0;
        w_q[15] <= nw1;
      end
    end
  end

  always_comb begin
    wout = '0;
    for (int unsigned i = 0; i < 16; i++) wout[i*WORD_S +: WORD_S] = w_q[i];
  end

endmodule

// File: tb/tb_w_expand_stage.sv
// Bench for w_expand_stage: four configurations share one stimulus stream and
// are checked against a whole-sequence reference expansion.
module tb_w_expand_stage;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready;
  logic [511:0]  win32;
  logic [1023:0] win64;
  logic          ir0, ov0, by0, ir1, ov1, by1, ir2, ov2, by2, ir3, ov3, by3;
  logic [511:0]  wo0, wo1, wo2;
  logic [1023:0] wo3;

  int ncmp = 0;
  int nfail = 0;
  int lat [4];
  localparam int WS  [4] = '{32, 32, 32, 64};
  localparam int WPS [4] = '{16, 1, 16, 1};
  localparam int LN  [4] = '{1, 1, 2, 1};

  logic [63:0] cur32 [16];
  logic [63:0] cur64 [16];
  logic [63:0] r [16];

  always #5 clk = ~clk;

  w_expand_stage #(.WORD_S(32), .WORDS_PER_STAGE(16), .LANES(1)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .win(win32),
    .out_valid(ov0), .out_ready(out_ready), .wout(wo0), .busy(by0));
  w_expand_stage #(.WORD_S(32), .WORDS_PER_STAGE(1), .LANES(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .win(win32),
    .out_valid(ov1), .out_ready(out_ready), .wout(wo1), .busy(by1));
  w_expand_stage #(.WORD_S(32), .WORDS_PER_STAGE(16), .LANES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .win(win32),
    .out_valid(ov2), .out_ready(out_ready), .wout(wo2), .busy(by2));
  w_expand_stage #(.WORD_S(64), .WORDS_PER_STAGE(1), .LANES(1)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3), .win(win64),
    .out_valid(ov3), .out_ready(out_ready), .wout(wo3), .busy(by3));

  function automatic logic [63:0] outw(input int k, input int i);
    case (k)
      0:       return {32'h0, wo0[i*32 +: 32]};
      1:       return {32'h0, wo1[i*32 +: 32]};
      2:       return {32'h0, wo2[i*32 +: 32]};
      default: return wo3[i*64 +: 64];
    endcase
  endfunction

  function automatic logic ovk(input int k);
    case (k)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic [63:0] msk(input int ws);
    return (ws == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int ws);
    return ((x >> n) | (x << (ws - n))) & msk(ws);
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input int ws);
    if (ws == 32) return rr(x, 7, ws) ^ rr(x, 18, ws) ^ (x >> 3);
    return rr(x, 1, ws) ^ rr(x, 8, ws) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input int ws);
    if (ws == 32) return rr(x, 17, ws) ^ rr(x, 19, ws) ^ (x >> 10);
    return rr(x, 19, ws) ^ rr(x, 61, ws) ^ (x >> 6);
  endfunction

  // Builds the full extended sequence E[] and returns E[wps .. wps+15].
  task automatic ref_expand(input logic [63:0] w [16], input int ws, input int wps,
                            output logic [63:0] res [16]);
    logic [63:0] e [64];
    for (int i = 0; i < 16; i++) e[i] = w[i] & msk(ws);
    for (int j = 16; j < 16 + wps; j++)
      e[j] = (s1(e[j-2], ws) + e[j-7] + s0(e[j-15], ws) + e[j-16]) & msk(ws);
    for (int i = 0; i < 16; i++) res[i] = e[wps + i];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers cur32/cur64 to all four instances (all must be IDLE or HOLD), then
  // runs with out_ready low and junk on the input side until all finish.
  task automatic txn(input string name);
    for (int i = 0; i < 16; i++) begin
      win32[i*32 +: 32] = cur32[i][31:0];
      win64[i*64 +: 64] = cur64[i];
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({name, "_busy_after_accept"}, 64'(by0), 64'd1);
    chk({name, "_ov_after_accept"}, 64'(ov0), 64'd0);
    chk({name, "_ir_in_calc"}, 64'(ir0), 64'd0);
    for (int k = 0; k < 4; k++) lat[k] = -1;
    for (int c = 1; c <= 24; c++) begin
      in_valid = 1'($urandom);
      win32 = {16{$urandom}};
      win64 = {32{$urandom}};
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
        if (ovk(k) && lat[k] < 0) lat[k] = c;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_latency_u%0d", name, k), 64'(lat[k]), 64'(WPS[k] / LN[k]));
      if (k == 3) ref_expand(cur64, WS[k], WPS[k], r);
      else        ref_expand(cur32, WS[k], WPS[k], r);
      for (int i = 0; i < 16; i++)
        chk($sformatf("%s_u%0d_w%0d", name, k, i), outw(k, i), r[i]);
    end
  endtask

  task automatic rand_windows();
    for (int i = 0; i < 16; i++) begin
      cur32[i] = {32'h0, $urandom};
      cur64[i] = {$urandom, $urandom};
    end
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    win32 = '0;
    win64 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(ir0), 64'd0);
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_busy", 64'(by0), 64'd0);
    chk("reset_in_ready_u3", 64'(ir3), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 64'(ir0), 64'd1);
    chk("post_reset_busy", 64'(by0), 64'd0);

    for (int i = 0; i < 16; i++) begin
      cur32[i] = '0;
      cur64[i] = '0;
    end
    cur32[0]  = 64'h6162_6380;
    cur32[15] = 64'h0000_0018;
    cur64[1]  = 64'd1;
    txn("abc");
    chk("abc_u0_w0_const", outw(0, 0), 64'h6162_6380);
    chk("abc_u0_w1_const", outw(0, 1), 64'h000F_0000);
    chk("abc_u1_w0_const", outw(1, 0), 64'h0);
    chk("abc_u1_w14_const", outw(1, 14), 64'h18);
    chk("abc_u1_w15_const", outw(1, 15), 64'h6162_6380);
    chk("abc_u2_w1_const", outw(2, 1), 64'h000F_0000);
    chk("d64_u3_w0_const", outw(3, 0), 64'h1);
    chk("d64_u3_w15_const", outw(3, 15), 64'h8100_0000_0000_0000);

    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(ov0), 64'd1);
      chk("bp_busy", 64'(by0), 64'd1);
      chk("bp_in_ready", 64'(ir0), 64'd0);
      chk("bp_w0_stable", outw(0, 0), 64'h6162_6380);
      chk("bp_w1_stable", outw(0, 1), 64'h000F_0000);
    end
    in_valid = 1'b0;

    rand_windows();
    txn("hold_to_calc");

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_valid", 64'(ov0), 64'd0);
    chk("idle_busy", 64'(by0), 64'd0);
    chk("idle_in_ready", 64'(ir0), 64'd1);

    win32 = {16{$urandom}};
    win64 = {32{$urandom}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midcalc_reset_in_ready", 64'(ir0), 64'd0);
    chk("midcalc_reset_busy", 64'(by0), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("after_reset_in_ready", 64'(ir0), 64'd1);
    chk("after_reset_out_valid", 64'(ov0), 64'd0);
    chk("after_reset_busy", 64'(by0), 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov0) seen = 1'b1;
    end
    chk("abandoned_no_out_valid", 64'(seen), 64'd0);

    for (int t = 0; t < 6; t++) begin
      rand_windows();
      txn($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/w_expand_stage.md
W_EXPAND_STAGE -- requirements
Module: w_expand_stage

Interface
REQ-001 SHALL have parameter WORD_S, default 32, meaning word width; legal values 32 (SHA-256 schedule) or 64 (SHA-512 schedule).
REQ-002 SHALL have parameter WORDS_PER_STAGE, default 16, meaning schedule words generated per transaction; legal range 1..48.
REQ-003 SHALL have parameter LANES, default 1, meaning words computed per clock; legal values 1 or 2; WORDS_PER_STAGE % LANES must be 0.
REQ-004 SHALL fail elaboration on any illegal parameter combination.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 in_valid  input  1  win holds a valid 16-word window.
REQ-008 in_ready  output  1  block accepts a window this cycle.
REQ-009 win  input  16*WORD_S  input window; word i at bits [i*WORD_S +: WORD_S]; word 0 is oldest.
REQ-010 out_valid  output  1  wout holds a valid result.
REQ-011 out_ready  input  1  downstream accepts wout this cycle.
REQ-012 wout  output  16*WORD_S  output window; same word packing as win.
REQ-013 busy  output  1  high in CALC or HOLD.

Function
REQ-014 SHALL treat the extended sequence E[0..15] = win words and E[16..15+WORDS_PER_STAGE] = generated words.
REQ-015 Each generated word SHALL be E[j] = sig1(E[j-2]) + E[j-7] + sig0(E[j-15]) + E[j-16], computed modulo 2^WORD_S.
REQ-016 For WORD_S=32: sig0 = ROTR7^ROTR18^SHR3; sig1 = ROTR17^ROTR19^SHR10.
REQ-017 For WORD_S=64: sig0 = ROTR1^ROTR8^SHR7; sig1 = ROTR19^ROTR61^SHR6.
REQ-018 wout word i SHALL equal E[WORDS_PER_STAGE + i] for i = 0..15.
REQ-019 FSM states SHALL be IDLE, CALC and HOLD.
REQ-020 IDLE: in_ready=1; on in_valid&in_ready the block latches win, clears the word counter and moves to CALC.
REQ-021 CALC: each clock the block writes LANES words (E[16+cnt], and E[17+cnt] when LANES=2) and advances cnt by LANES; in_ready=0 and out_valid=0.
REQ-022 CALC -> HOLD on the edge that writes the last word; total CALC duration is exactly WORDS_PER_STAGE/LANES cycles.
REQ-023 Latency SHALL be WORDS_PER_STAGE/LANES cycles, from the accepting edge to out_valid high.
REQ-024 HOLD: out_valid=1; wout stable until out_valid&out_ready.
REQ-025 In HOLD, in_ready SHALL equal out_ready.
REQ-026 Output and input handshakes in the same HOLD cycle SHALL go directly to CALC with the new window; sustained throughput is one window per WORDS_PER_STAGE/LANES+1 cycles.
REQ-027 HOLD with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-028 in_valid during CALC SHALL be ignored, with no state or data change.
REQ-029 The word counter SHALL never exceed WORDS_PER_STAGE-LANES, with no wrap-around.

Reset
REQ-030 While reset=1, outputs SHALL be: in_ready=0, out_valid=0, busy=0.
REQ-031 On the first cycle after reset deasserts, the state SHALL be IDLE with in_ready=1.
REQ-032 Reset asserted in CALC or HOLD SHALL abandon the transaction, and no out_valid shall follow.
REQ-033 Window and result registers SHALL NOT be reset, and wout SHALL be checked only while out_valid=1.

Verification
REQ-034 WORD_S=32, WPS=16, LANES=1; win = "abc" padded block (w0=0x61626380, w15=0x00000018, other words 0) -> out_valid after exactly 16 cycles; wout word0=0x61626380, word1=0x000F0000.
REQ-035 Same window with WPS=1 -> out_valid after 1 cycle; wout words 0..13=0, word14=0x00000018, word15=0x61626380.
REQ-036 WPS=16, LANES=2, same window -> out_valid after 8 cycles; wout identical to REQ-034.
REQ-037 WORD_S=64, WPS=1; win w1=1, other words 0 -> wout word15=0x8100000000000000, word0=1, words 1..14=0.
REQ-038 Back-pressure: out_ready=0 for 5 cycles in HOLD -> out_valid, busy and wout stable, in_ready=0; then out_ready=1 with in_valid=1 -> new CALC starts on the next cycle with no IDLE cycle.
REQ-039 Reset pulsed for 1 cycle mid-CALC -> out_valid stays 0, in_ready=1 on the cycle after reset; a following transaction produces correct results.
